ber_phase_sweep_ctrl: RTL and testbench
=======================================

Name: ber_phase_sweep_ctrl

Overview:
Sequencer for the BER checker. It sweeps the checker's phase selector over all N_PHASES phases. At each phase it restarts the checker, waits for MEAS_SAMPLES counted samples and captures the error count. It then picks the phase with the fewest errors, configures the checker at that phase and leaves it running in a lock state. It sits between the control/register interface and the BER checker's i_en / i_phase_sel inputs.

Parameters:
N_PHASES, 4, number of phases swept (power of 2)
NB_BER_CNT, 64, width of the checker's sample/error counters
MEAS_SAMPLES, 1024, counted samples per phase measurement; must exceed the checker's per-position sync window
GAP_CYCLES, 4, cycles o_ber_en is held low to restart the checker (min 2)
TIMEOUT, 2**24, max cycles in RUN per phase before forced capture
NB_TMO, 25, width of the RUN cycle counter (at least clog2(TIMEOUT)+1)

Ports:
clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start sweep; single-cycle pulse or level, sampled in IDLE/LOCK only
i_ber_samp  in  NB_BER_CNT  checker sample counter (o_ber_samp)
i_ber_error  in  NB_BER_CNT  checker error counter (o_ber_error)
o_ber_en  out  1  drives checker i_en
o_phase_sel  out  N_PHASES  drives checker i_phase_sel; value = phase index, zero-extended
o_busy  out  1  high in GAP/RUN/EVAL/LGAP
o_done  out  1  one-cycle pulse on entry to LOCK
o_best_phase  out  clog2(N_PHASES)  winning phase, valid from o_done
o_best_err  out  NB_BER_CNT  error count of winning phase
o_timeout  out  1  sticky: a phase hit TIMEOUT in the current sweep

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_ber_en=0; o_phase_sel=0; o_busy=0; o_done=0; o_best_phase=0; o_best_err=all ones; o_timeout=0; phase_idx=0; gap_cnt=0; tmo_cnt=0. Reset mid-sweep aborts immediately; no partial result is kept.
- All outputs are registered. o_phase_sel changes only while o_ber_en=0.
- States:
  - IDLE: o_ber_en=0. On i_start=1: phase_idx=0, best_err=all ones, best_phase=0, o_timeout=0, o_phase_sel=0, go to GAP.
  - GAP: o_ber_en=0 for exactly GAP_CYCLES cycles, counted by gap_cnt. Then go to RUN with o_ber_en=1 and tmo_cnt=0.
  - RUN: o_ber_en=1; tmo_cnt increments every cycle.
    - If i_ber_samp >= MEAS_SAMPLES: meas_err=i_ber_error, go to EVAL.
    - Else if tmo_cnt == TIMEOUT-1: meas_err=all ones, o_timeout<=1, go to EVAL.
    - If both hold in the same cycle, the sample condition wins.
  - EVAL (1 cycle, o_ber_en=0): if meas_err < best_err (strict), update best_err and best_phase. Ties keep the lower phase.
    - If phase_idx == N_PHASES-1: o_phase_sel=best (using the just-updated value), go to LGAP.
    - Else: phase_idx+1, o_phase_sel=phase_idx+1, go to GAP.
  - LGAP: same as GAP (GAP_CYCLES cycles, o_ber_en=0). Then go to LOCK; o_done=1 for the entry cycle.
  - LOCK: o_ber_en=1, o_phase_sel=best_phase, o_busy=0. i_start=1 restarts the sweep exactly as from IDLE.
- i_start is ignored in GAP/RUN/EVAL/LGAP.
- The GAP duration of o_ber_en=0 walks the checker through STOP and back to RESET before re-synchronisation.
- Comparisons are unsigned at NB_BER_CNT width. meas_err=all ones on timeout never beats a real measurement; if every phase times out, best_phase=0.
- Measurement latency per phase is GAP_CYCLES + RUN cycles + 1.

Decomposition:
- Shared package ber_pkg: state encodings (IDLE, GAP, RUN, EVAL, LGAP, LOCK, 3 bits), default MEAS_SAMPLES/GAP_CYCLES/TIMEOUT, and NB_BER_CNT, shared with the BER checker.
- One natural sub-module, ber_min_tracker: registers the minimum error count and its phase. Inputs: clear, load, value, index. Outputs: best value and best index.

Test Plan:
- Reset mid-RUN at phase 2 -> o_ber_en=0, o_busy=0, o_phase_sel=0, o_best_err=all ones asynchronously, no o_done.
- i_start; model returns samp ramp, error=30,5,12,5 for phases 0..3 -> o_phase_sel sweeps 0,1,2,3 with o_ber_en low 4 cycles before each phase; o_done pulse; o_best_phase=1 (tie with 3 keeps 1), o_best_err=5, o_ber_en=1, o_phase_sel=1 in LOCK.
- i_ber_samp stuck at 0 for phase 1, TIMEOUT=64, errors 9,x,3,7 -> RUN for phase 1 exits after exactly 64 cycles, o_timeout=1, o_best_phase=2, o_best_err=3.
- i_ber_samp reaches MEAS_SAMPLES in the same cycle tmo_cnt=TIMEOUT-1 -> sample capture wins, o_timeout stays 0.
- i_start pulses during GAP and RUN -> no effect; sweep completes once with one o_done pulse.
- i_start in LOCK -> o_ber_en drops for GAP_CYCLES, o_phase_sel=0, o_timeout cleared, a new sweep runs and o_done pulses again.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker and its phase-sweep sequencer.
package ber_pkg;

  // Counter width shared with the BER checker's sample/error counters.
  localparam int unsigned NB_BER_CNT_DEF   = 64;
  localparam int unsigned MEAS_SAMPLES_DEF = 1024;
  localparam int unsigned GAP_CYCLES_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF      = 2**24;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGap  = 3'd1,
    StRun  = 3'd2,
    StEval = 3'd3,
    StLgap = 3'd4,
    StLock = 3'd5
  } ber_state_e;

endpackage

// File: rtl/ber_min_tracker.sv
// Holds the lowest error count seen in a sweep and the phase that produced it.
module ber_min_tracker #(
  parameter int unsigned NB_VAL = 64,
  parameter int unsigned NB_IDX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [NB_VAL-1:0] value,
  input  logic [NB_IDX-1:0] index,
  output logic [NB_VAL-1:0] best_val,
  output logic [NB_IDX-1:0] best_idx
);

  // Strictly-lower update so ties keep the earlier (lower) phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val <= '1;
      best_idx <= '0;
    end else if (clear) begin
      best_val <= '1;
      best_idx <= '0;
    end else if (load && (value < best_val)) begin
      best_val <= value;
      best_idx <= index;
    end
  end

endmodule

// File: rtl/ber_phase_sweep_ctrl.sv
// Sweeps the BER checker over all phases, keeps the quietest one and locks onto it.
module ber_phase_sweep_ctrl
  import ber_pkg::*;
#(
  parameter int unsigned N_PHASES     = 4,
  parameter int unsigned NB_BER_CNT   = NB_BER_CNT_DEF,
  parameter int unsigned MEAS_SAMPLES = MEAS_SAMPLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned NB_TMO       = 25,
  localparam int unsigned PH_W        = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_BER_CNT-1:0] i_ber_samp,
  input  logic [NB_BER_CNT-1:0] i_ber_error,
  output logic                  o_ber_en,
  output logic [N_PHASES-1:0]   o_phase_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PH_W-1:0]       o_best_phase,
  output logic [NB_BER_CNT-1:0] o_best_err,
  output logic                  o_timeout
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;

  ber_state_e            state_q, state_d;
  logic [PH_W-1:0]       phase_idx_q, phase_idx_d;
  logic [PH_W-1:0]       phase_sel_q, phase_sel_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [NB_TMO-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [NB_BER_CNT-1:0] meas_err_q, meas_err_d;
  logic                  ber_en_q, ber_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  trk_clear, trk_load, eval_wins;

  ber_min_tracker #(
    .NB_VAL (NB_BER_CNT),
    .NB_IDX (PH_W)
  ) u_min_tracker (
    .clk      (clk),
    .rst      (i_rst),
    .clear    (trk_clear),
    .load     (trk_load),
    .value    (meas_err_q),
    .index    (phase_idx_q),
    .best_val (o_best_err),
    .best_idx (o_best_phase)
  );

  // Next-state and next-output decode; the tracker updates in step with EVAL.
  always_comb begin
    state_d     = state_q;
    phase_idx_d = phase_idx_q;
    phase_sel_d = phase_sel_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    meas_err_d  = meas_err_q;
    ber_en_d    = ber_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    trk_clear   = 1'b0;
    trk_load    = 1'b0;
    // Mirrors the tracker's compare so the final phase select sees the updated winner.
    eval_wins   = (meas_err_q < o_best_err);

    case (state_q)
      StIdle, StLock: begin
        if (i_start) begin
          phase_idx_d = '0;
          phase_sel_d = '0;
          gap_cnt_d   = '0;
          timeout_d   = 1'b0;
          ber_en_d    = 1'b0;
          busy_d      = 1'b1;
          trk_clear   = 1'b1;
          state_d     = StGap;
        end
      end
      StGap, StLgap: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          ber_en_d  = 1'b1;
          if (state_q == StGap) begin
            tmo_cnt_d = '0;
            state_d   = StRun;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StLock;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StRun: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // Sample condition has priority over the timeout.
        if (i_ber_samp >= NB_BER_CNT'(MEAS_SAMPLES)) begin
          meas_err_d = i_ber_error;
          ber_en_d   = 1'b0;
          state_d    = StEval;
        end else if (tmo_cnt_q == NB_TMO'(TIMEOUT - 1)) begin
          meas_err_d = '1;
          timeout_d  = 1'b1;
          ber_en_d   = 1'b0;
          state_d    = StEval;
        end
      end
      StEval: begin
        trk_load  = 1'b1;
        gap_cnt_d = '0;
        if (phase_idx_q == PH_W'(N_PHASES - 1)) begin
          phase_sel_d = eval_wins ? phase_idx_q : o_best_phase;
          state_d     = StLgap;
        end else begin
          phase_idx_d = phase_idx_q + 1'b1;
          phase_sel_d = phase_idx_q + 1'b1;
          state_d     = StGap;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      phase_idx_q <= '0;
      phase_sel_q <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      meas_err_q  <= '1;
      ber_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_idx_q <= phase_idx_d;
      phase_sel_q <= phase_sel_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      meas_err_q  <= meas_err_d;
      ber_en_q    <= ber_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Zero-extend the phase index onto the checker's select bus.
  always_comb begin
    o_phase_sel             = '0;
    o_phase_sel[PH_W-1:0]   = phase_sel_q;
  end

  assign o_ber_en  = ber_en_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_ber_phase_sweep_ctrl.sv
// Directed bench: table of sweep scenarios plus hand-written reset/start sequences.
module tb_ber_phase_sweep_ctrl;

  localparam int unsigned MEAS   = 16;
  localparam int unsigned GAP    = 4;
  localparam int unsigned TMO    = 64;
  localparam int unsigned LATE   = TMO - 1 - MEAS;
  localparam logic [1:0]  M_NORM  = 2'd0;
  localparam logic [1:0]  M_STUCK = 2'd1;
  localparam logic [1:0]  M_LATE  = 2'd2;
  localparam logic [63:0] ONES    = '1;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [63:0] i_ber_samp;
  logic [63:0] i_ber_error;
  logic        o_ber_en;
  logic [3:0]  o_phase_sel;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_best_phase;
  logic [63:0] o_best_err;
  logic        o_timeout;

  always #5 clk = ~clk;

  ber_phase_sweep_ctrl #(
    .N_PHASES     (4),
    .NB_BER_CNT   (64),
    .MEAS_SAMPLES (MEAS),
    .GAP_CYCLES   (GAP),
    .TIMEOUT      (TMO),
    .NB_TMO       (8)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_ber_samp   (i_ber_samp),
    .i_ber_error  (i_ber_error),
    .o_ber_en     (o_ber_en),
    .o_phase_sel  (o_phase_sel),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_best_phase (o_best_phase),
    .o_best_err   (o_best_err),
    .o_timeout    (o_timeout)
  );

  // Checker model: sample counter runs while enabled, cleared while disabled.
  logic [3:0][1:0]  cur_mode = '0;
  logic [3:0][63:0] cur_err  = '0;
  logic [63:0]      run_ctr  = '0;

  function automatic logic [63:0] model_samp(input logic [1:0] m, input logic [63:0] c);
    case (m)
      M_STUCK: return 64'd0;
      M_LATE:  return (c >= 64'(LATE)) ? c - 64'(LATE) : 64'd0;
      default: return c;
    endcase
  endfunction

  function automatic int exp_len(input logic [1:0] m);
    return (m == M_NORM) ? int'(MEAS) + 1 : int'(TMO);
  endfunction

  always @(posedge clk) begin
    if (!o_ber_en) run_ctr <= '0;
    else           run_ctr <= run_ctr + 64'd1;
  end

  assign i_ber_samp  = model_samp(cur_mode[o_phase_sel[1:0]], run_ctr);
  assign i_ber_error = cur_err[o_phase_sel[1:0]];

  // Output monitor: records each enable rise (phase, preceding low run) and run length.
  int         n_rise, n_done, low_cnt, run_cur, sel_viol;
  int         rise_sel [8];
  int         rise_low [8];
  int         rise_len [8];
  logic       prev_en = 1'b0;
  logic [3:0] prev_sel = '0;
  logic       mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_rise = 0; n_done = 0; sel_viol = 0;
      for (int k = 0; k < 8; k++) begin
        rise_sel[k] = -1; rise_low[k] = -1; rise_len[k] = -1;
      end
    end
    if (o_done) n_done++;
    if (prev_en && o_ber_en && (o_phase_sel != prev_sel)) sel_viol++;
    if (o_ber_en && !prev_en) begin
      if (n_rise < 8) begin
        rise_sel[n_rise] = int'(o_phase_sel);
        rise_low[n_rise] = low_cnt;
      end
      n_rise++;
      run_cur = 0;
    end
    if (o_ber_en) run_cur++;
    if (!o_ber_en && prev_en && n_rise > 0 && n_rise <= 8) rise_len[n_rise-1] = run_cur;
    if (!o_ber_en && o_busy) low_cnt = (o_phase_sel == prev_sel) ? low_cnt + 1 : 1;
    else                     low_cnt = 0;
    prev_en  = o_ber_en;
    prev_sel = o_phase_sel;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][1:0]  mode;
    logic [3:0][63:0] err;
    logic [1:0]       exp_phase;
    logic [63:0]      exp_err;
    logic             exp_tmo;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m0, m1, m2, m3,
                              input logic [63:0] e0, e1, e2, e3,
                              input logic [1:0] ph, input logic [63:0] be, input logic tm);
    vec_t v;
    v.mode[0] = m0; v.mode[1] = m1; v.mode[2] = m2; v.mode[3] = m3;
    v.err[0]  = e0; v.err[1]  = e1; v.err[2]  = e2; v.err[3]  = e3;
    v.exp_phase = ph; v.exp_err = be; v.exp_tmo = tm;
    return v;
  endfunction

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_rise(input int n, input string name);
    bit got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (n_rise >= n) begin got = 1'b1; break; end
    end
    chk({name, "_reached"}, 64'(got), 64'd1);
  endtask

  task automatic run_sweep(input vec_t v, input string name, input bit interfere);
    bit got = 1'b0;
    cur_mode = v.mode;
    cur_err  = v.err;
    clear_mon();
    pulse_start();
    @(negedge clk); #1;
    chk({name, "_start_en"},   64'(o_ber_en),    64'd0);
    chk({name, "_start_sel"},  64'(o_phase_sel), 64'd0);
    chk({name, "_start_tmo"},  64'(o_timeout),   64'd0);
    chk({name, "_start_busy"}, 64'(o_busy),      64'd1);
    if (interfere) begin
      pulse_start();
      wait_rise(2, {name, "_ph1"});
      repeat (3) @(posedge clk);
      pulse_start();
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (o_done) begin got = 1'b1; break; end
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    if (!got) return;
    chk({name, "_best_phase"}, 64'(o_best_phase), 64'(v.exp_phase));
    chk({name, "_best_err"},   o_best_err,        v.exp_err);
    chk({name, "_timeout"},    64'(o_timeout),    64'(v.exp_tmo));
    chk({name, "_lock_en"},    64'(o_ber_en),     64'd1);
    chk({name, "_lock_sel"},   64'(o_phase_sel),  64'(v.exp_phase));
    chk({name, "_lock_busy"},  64'(o_busy),       64'd0);
    @(negedge clk); #1;
    chk({name, "_done_pulse"}, 64'(o_done), 64'd0);
    chk({name, "_n_done"},     64'(n_done), 64'd1);
    chk({name, "_n_rise"},     64'(n_rise), 64'd5);
    chk({name, "_sel_stable"}, 64'(sel_viol), 64'd0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_ph%0d_sel", name, p), 64'(rise_sel[p]), 64'(p));
      chk($sformatf("%s_ph%0d_gap", name, p), 64'(rise_low[p]), 64'(GAP));
      chk($sformatf("%s_ph%0d_run", name, p), 64'(rise_len[p]), 64'(exp_len(v.mode[p])));
    end
    chk({name, "_lock_rise_sel"}, 64'(rise_sel[4]), 64'(v.exp_phase));
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = mk(M_NORM, M_NORM, M_NORM, M_NORM, 30, 5, 12, 5, 2'd1, 64'd5, 1'b0);
    vecs[1] = mk(M_NORM, M_STUCK, M_NORM, M_NORM, 9, 99, 3, 7, 2'd2, 64'd3, 1'b1);
    vecs[2] = mk(M_NORM, M_NORM, M_LATE, M_NORM, 20, 20, 20, 20, 2'd0, 64'd20, 1'b0);
    vecs[3] = mk(M_STUCK, M_STUCK, M_STUCK, M_STUCK, 1, 1, 1, 1, 2'd0, ONES, 1'b1);
    vecs[4] = mk(M_NORM, M_NORM, M_NORM, M_NORM, 40, 30, 20, 10, 2'd3, 64'd10, 1'b0);

    i_rst   = 1'b1;
    i_start = 1'b0;
    #3;
    chk("rst_en",    64'(o_ber_en),     64'd0);
    chk("rst_sel",   64'(o_phase_sel),  64'd0);
    chk("rst_busy",  64'(o_busy),       64'd0);
    chk("rst_done",  64'(o_done),       64'd0);
    chk("rst_phase", 64'(o_best_phase), 64'd0);
    chk("rst_err",   o_best_err,        ONES);
    chk("rst_tmo",   64'(o_timeout),    64'd0);
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    // Reset in the middle of phase 2's measurement.
    cur_mode = vecs[0].mode;
    cur_err  = vecs[0].err;
    clear_mon();
    pulse_start();
    wait_rise(3, "mid_ph2");
    repeat (3) @(negedge clk);
    #1;
    chk("mid_pre_en",  64'(o_ber_en),    64'd1);
    chk("mid_pre_sel", 64'(o_phase_sel), 64'd2);
    #1 i_rst = 1'b1;
    #1;
    chk("mid_rst_en",    64'(o_ber_en),     64'd0);
    chk("mid_rst_busy",  64'(o_busy),       64'd0);
    chk("mid_rst_sel",   64'(o_phase_sel),  64'd0);
    chk("mid_rst_err",   o_best_err,        ONES);
    chk("mid_rst_phase", 64'(o_best_phase), 64'd0);
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    clear_mon();
    repeat (150) @(negedge clk);
    #1;
    chk("mid_no_done", 64'(n_done),   64'd0);
    chk("mid_idle_en", 64'(o_ber_en), 64'd0);
    chk("mid_idle_busy", 64'(o_busy), 64'd0);

    // Table sweeps; each after the first restarts from LOCK.
    for (int i = 0; i < 5; i++) run_sweep(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Start pulses during GAP and RUN must be ignored.
    run_sweep(vecs[0], "ignore_start", 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
